// File: rtl/result_display.sv
// result_display: steps through the 8x8 matrix-multiply result RAM, converts
// each signed word to decimal with a sequential double-dabble and drives six
// active-low seven-segment digits plus a sign LED.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module result_display #(
  parameter int RES_W  = 19,
  parameter int ADDR_W = 6,
  parameter int DIGITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic              step,
  input  logic [RES_W-1:0]  ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic              neg,
  output logic              busy
);

  localparam int         BCD_W = 4 * DIGITS;
  localparam int         CNT_W = $clog2(RES_W + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    CONVERT,
    SHOW
  } state_t;

  state_t             state, state_next;
  logic               step_q;
  logic               step_rise;
  logic               neg_next;
  logic [RES_W-1:0]   mag;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   iter;
  logic [6:0]         seg_q [DIGITS];
  logic [6:0]         seg_d [DIGITS];
  logic               abort;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign step_rise = step & ~step_q;
  assign abort     = (state != IDLE) && !done;
  assign busy      = (state == FETCH) || (state == LATCH) || (state == CONVERT);

  assign hex0 = seg_q[0];
  assign hex1 = seg_q[1];
  assign hex2 = seg_q[2];
  assign hex3 = seg_q[3];
  assign hex4 = seg_q[4];
  assign hex5 = seg_q[5];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; losing done aborts to IDLE ahead of any step.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (done) state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = CONVERT;
      CONVERT: if (iter == CNT_W'(RES_W - 1)) state_next = SHOW;
      SHOW:    if (step_rise) state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_nz;

  // Segment decode with leading zeros blanked; digit 0 always shows.
  always_comb begin
    higher_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg_d[i] = seg_decode(bcd[4*i +: 4]);
      if (bcd[4*i +: 4] != 4'd0) higher_nz = 1'b1;
      else if (!higher_nz && i != 0) seg_d[i] = SEG_BLANK;
    end
  end
`else
  // Segment decode showing all digits, leading zeros included.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) seg_d[i] = seg_decode(bcd[4*i +: 4]);
  end
`endif

  // Datapath: address, conversion registers and display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q   <= 1'b0;
      ram_addr <= '0;
      neg      <= 1'b0;
      neg_next <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      iter     <= '0;
      for (int i = 0; i < DIGITS; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      step_q <= step;
      if (abort || state == IDLE) begin
        ram_addr <= '0;
        neg      <= 1'b0;
        for (int i = 0; i < DIGITS; i++) seg_q[i] <= SEG_BLANK;
      end else begin
        case (state)
          LATCH: begin
            neg_next <= ram_rdata[RES_W-1];
            // Unsigned magnitude; the most negative word maps to 2^(RES_W-1).
            mag      <= ram_rdata[RES_W-1] ? (~ram_rdata + RES_W'(1)) : ram_rdata;
            bcd      <= '0;
            iter     <= '0;
          end
          CONVERT: begin
            {bcd, mag} <= {bcd_adj, mag} << 1;
            iter       <= iter + CNT_W'(1);
          end
          SHOW: begin
            neg <= neg_next;
            for (int i = 0; i < DIGITS; i++) seg_q[i] <= seg_d[i];
            if (step_rise) ram_addr <= ram_addr + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display, with a registered-read
// result RAM model. Build with LEADING_ZERO_BLANK_EN to exercise blanking.
module tb_result_display;

  localparam int RES_W  = 19;
  localparam int ADDR_W = 6;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [41:0] DISP_1234 = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [41:0] DISP_7    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [41:0] DISP_5    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12};
`else
  localparam logic [41:0] DISP_1234 = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [41:0] DISP_7    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78};
  localparam logic [41:0] DISP_5    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};
`endif
  localparam logic [41:0] DISP_MIN   = {7'h24, 7'h02, 7'h24, 7'h79, 7'h19, 7'h19};
  localparam logic [41:0] DISP_BLANK = {6{7'h7F}};

  logic              clk = 1'b0;
  logic              reset;
  logic              done;
  logic              step;
  logic [RES_W-1:0]  ram_rdata = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [6:0]        hex [6];
  logic              neg;
  logic              busy;

  logic [RES_W-1:0]  mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  result_display dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .step      (step),
    .ram_rdata (ram_rdata),
    .ram_addr  (ram_addr),
    .hex0      (hex[0]),
    .hex1      (hex[1]),
    .hex2      (hex[2]),
    .hex3      (hex[3]),
    .hex4      (hex[4]),
    .hex5      (hex[5]),
    .neg       (neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Registered-read result RAM.
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_display(input string tag, input logic [41:0] exp_disp, input logic exp_neg);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_hex%0d", tag, i), 32'(hex[i]), 32'(exp_disp[7*i +: 7]));
    check({tag, "_neg"}, 32'(neg), 32'(exp_neg));
  endtask

  // Called right after the trigger is applied at a negedge: busy for 21
  // cycles, display unchanged at edge N+21, updated at edge N+22.
  task automatic run_conv(input string tag, input logic [6:0] prev_h0,
                          input logic [41:0] exp_disp, input logic exp_neg);
    int busy_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd21);
    @(negedge clk);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_hold_hex0"}, 32'(hex[0]), 32'(prev_h0));
    @(negedge clk);
    check_display(tag, exp_disp, exp_neg);
  endtask

  task automatic step_and_wait();
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    repeat (23) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 19'd1234;
    mem[1]  = 19'h40000;
    mem[2]  = -19'sd5;
    mem[63] = 19'd7;

    // Test 1: reset dominates done and step.
    reset = 1'b0;
    done  = 1'b1;
    step  = 1'b1;
    repeat (3) @(negedge clk);
    check_display("reset", DISP_BLANK, 1'b0);
    check("reset_addr", 32'(ram_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Test 2: release reset with done high, RAM[0] = 1234.
    reset = 1'b1;
    run_conv("t2_1234", 7'h7F, DISP_1234, 1'b0);
    check("t2_addr_no_advance", 32'(ram_addr), 32'd0);

    // Test 3: step to RAM[1] = -262144.
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    run_conv("t3_min", 7'h19, DISP_MIN, 1'b1);
    check("t3_addr", 32'(ram_addr), 32'd1);

    // Test 4: walk to address 63, then wrap to 0.
    for (int k = 0; k < 62; k++) step_and_wait();
    check("t4_addr63", 32'(ram_addr), 32'd63);
    check_display("t4_seven", DISP_7, 1'b0);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    run_conv("t4_wrap", 7'h78, DISP_1234, 1'b0);
    check("t4_addr_wrap", 32'(ram_addr), 32'd0);

    // Test 5: step during CONVERT ignored; holding step high advances once.
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (17) @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_addr_ignored", 32'(ram_addr), 32'd1);
    check_display("t5_min", DISP_MIN, 1'b1);
    step = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_addr_once", 32'(ram_addr), 32'd2);
    check_display("t5_minus5", DISP_5, 1'b1);

    // Test 6: drop done in the 5th CONVERT cycle, then restart.
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check_display("t6_abort", DISP_BLANK, 1'b0);
    check("t6_abort_addr", 32'(ram_addr), 32'd0);
    check("t6_abort_busy", 32'(busy), 32'd0);
    done = 1'b1;
    run_conv("t6_redo", 7'h7F, DISP_1234, 1'b0);
    check("t6_redo_addr", 32'(ram_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Downstream stage of the 8x8 matrix-multiply engine.
- After the multiplier raises `done`, this block reads the 64-entry, 19-bit signed result RAM one word at a time and converts each word to decimal with a sequential double-dabble.
- It drives the six DE10-Lite seven-segment digits (HEX5..HEX0) plus a sign LED.
- The user steps through the result addresses with a push-button.

Parameters:
- RES_W, 19, width of a signed result word.
- ADDR_W, 6, result RAM address width (64 entries, wraps at 2^ADDR_W-1).
- DIGITS, 6, number of BCD digits / seven-segment displays.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- done  input  1  level from the multiplier; results in RAM are valid while high.
- step  input  1  level, active-high, already synchronised; a rising edge advances to the next address.
- ram_rdata  input  RES_W  result RAM read data; registered read, valid one cycle after ram_addr changes.
- ram_addr  output  ADDR_W  result RAM read address; registered.
- hex0..hex5  output  7 each  segments {g,f,e,d,c,b,a}, active-low; hex0 is the least significant digit.
- neg  output  1  high when the displayed value is negative.
- busy  output  1  high in FETCH, LATCH and CONVERT.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE, ram_addr=0, all hex=7'h7F (blank), neg=0, busy=0.
  - step edge-detector register cleared.
  - Reset overrides every other condition, including mid-conversion.
- Step edge detect: step_rise = step & ~step_q, where step_q is step registered each cycle.
- States:
  - IDLE: hex blank, neg=0, ram_addr=0. If done==1: ram_addr<=0, go to FETCH.
  - FETCH (1 cycle): RAM samples ram_addr. Go to LATCH.
  - LATCH (1 cycle): capture ram_rdata.
    - neg_next = ram_rdata[RES_W-1].
    - mag = two's-complement magnitude as an RES_W-bit unsigned value; -262144 yields 262144, with no overflow.
    - Clear the BCD shift register (4*DIGITS bits) and the iteration counter. Go to CONVERT.
  - CONVERT (RES_W cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1. After the RES_W-th iteration, go to SHOW.
  - SHOW:
    - On entry edge: hex registers loaded from the BCD nibbles through the segment decoder, and neg loaded from neg_next.
    - While in SHOW, on step_rise: ram_addr<=ram_addr+1 (63 wraps to 0), go to FETCH.
- Latency: with edge N detecting step_rise (or done in IDLE), hex/neg update at edge N+22. Outputs hold their previous values until then.
- step_rise outside SHOW is ignored, not queued. Holding step high causes exactly one advance.
- done==0 in any non-IDLE state: next edge goes to IDLE, blanks hex, clears neg, sets ram_addr=0, busy=0. This takes priority over step_rise.
- Segment codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - blank=7F
- Maximum magnitude is 262144, which fits in 6 digits. No overflow case exists.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits above the most significant nonzero digit show 7F.
  - The value 0 shows "0" on hex0 only.
  - The blanking is decided at SHOW load and adds no latency.
- Undefined: all six digits are always shown, including leading zeros.

Test Plan:
1. Hold reset=0 for 3 cycles with done=1 and step=1 -> hex0..hex5=7F, ram_addr=0, neg=0, busy=0. After release, state enters FETCH with no advance.
2. RAM[0]=1234, raise done -> busy high for 21 cycles; at edge N+22, hex5..hex0=40,40,79,24,30,19 and neg=0. With LEADING_ZERO_BLANK_EN: hex5,hex4=7F.
3. RAM[1]=-262144 (19'h40000), pulse step -> ram_addr=1; hex5..hex0=24,02,24,79,19,19; neg=1.
4. ram_addr=63, pulse step -> ram_addr=0 and the display shows the RAM[0] value.
5. Pulse step during CONVERT, then hold step high for 100 cycles in SHOW -> exactly one address increment in total.
6. Drop done at the 5th CONVERT cycle -> next edge: IDLE, hex all 7F, ram_addr=0. Re-raise done -> RAM[0] redisplayed after 22 cycles.
